mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADRS_W, default 6: memory address width.
REQ-002 Parameter DATA_W, default 8: memory data width.
REQ-003 Parameter RD_LAT, default 2: cycles from address drive to valid mem_out; legal range 1..15.
REQ-004 Parameter WR_LAT, default 3: cycles mem_mode is held high per write; legal range 1..15.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 req0 / req1  input  1 each  requester 0 (CPU) / requester 1 (front-panel loader) access request.
REQ-008 we0 / we1  input  1 each  1 = write, 0 = read; sampled with the request.
REQ-009 adrs0 / adrs1  input  ADRS_W each  requester address.
REQ-010 wdata0 / wdata1  input  DATA_W each  requester write data.
REQ-011 gnt0 / gnt1  output  1 each  high while that requester owns the memory.
REQ-012 done0 / done1  output  1 each  one-cycle completion pulse.
REQ-013 rdata  output  DATA_W  read result, shared by both requesters.
REQ-014 busy  output  1  high whenever either gnt is high.
REQ-015 mem_adrs  output  ADRS_W  memory address.
REQ-016 mem_mode  output  1  memory write enable (1 = write).
REQ-017 mem_data  output  DATA_W  memory write data.
REQ-018 mem_out  input  DATA_W  memory read data.

Function
REQ-019 FSM states IDLE, READ, WRITE; a down-counter cnt (4 bits) times each access; all outputs registered.
REQ-020 Requests are sampled only in IDLE; req is ignored in READ/WRITE.
REQ-021 Arbitration in IDLE: only req0 -> grant 0; only req1 -> grant 1; both -> grant the requester not granted last (round-robin bit last_gnt).
REQ-022 At the grant edge (cycle G): gnt of the winner rises; its we, adrs and wdata are latched into mem_adrs/mem_data; FSM goes to READ (we=0) or WRITE (we=1).
REQ-023 Changes to adrs/wdata/we after cycle G do not affect the transaction in flight.
REQ-024 Read: mem_mode stays 0; at the edge ending cycle G+RD_LAT-1, mem_out is captured into rdata; done pulses in cycle G+RD_LAT; gnt stays high in cycles G..G+RD_LAT and falls at G+RD_LAT+1.
REQ-025 Write: mem_mode is 1 in cycles G..G+WR_LAT-1 and 0 from G+WR_LAT; done pulses in cycle G+WR_LAT; gnt falls at G+WR_LAT+1.
REQ-026 The FSM returns to IDLE at the edge ending the done cycle; the earliest next grant is cycle done+2 (one IDLE cycle always separates transactions).
REQ-027 Requester protocol: req must be low by the cycle after its done; a req still high in IDLE is treated as a new request.
REQ-028 Dropping req during READ/WRITE does not abort; the access completes and done still pulses.
REQ-029 rdata holds its value until the next read completes; writes do not alter it.
REQ-030 At most one gnt and at most one done are high in any cycle; busy = gnt0 | gnt1.
REQ-031 last_gnt updates at each grant edge to the index of the requester granted.

Reset
REQ-032 rst_n low, at any time including mid-transaction, immediately forces: state IDLE, cnt 0, gnt0/gnt1/done0/done1/busy 0, mem_mode 0, mem_adrs 0, mem_data 0, rdata 0, last_gnt 1 (so requester 0 wins the first tie).
REQ-033 A write interrupted by reset is not completed or retried after reset; its requester must reissue.

Verification
REQ-034 Single read: mem[5]=8'hA7, req0=1 we0=0 adrs0=5 at G-1 -> gnt0 high G..G+2, done0 pulse at G+2, rdata=8'hA7 from G+2, mem_mode 0 throughout.
REQ-035 Single write: req1=1 we1=1 adrs1=9 wdata1=8'h3C -> mem_mode high exactly 3 cycles with mem_adrs=9 mem_data=8'h3C, done1 at G+3, subsequent read of 9 returns 8'h3C.
REQ-036 Tie round-robin: req0 and req1 held high continuously from reset -> grant order 0,1,0,1 with one IDLE cycle between transactions.
REQ-037 Latch check: during a grant-0 read of adrs 5, change adrs0 to 6 at G+1 and drop req0 -> mem_adrs stays 5, done0 still pulses, rdata=mem[5].
REQ-038 Reset mid-write: rst_n low at G+1 of a write -> mem_mode, gnt, busy 0 in same cycle; after release, simultaneous requests grant requester 0 first.
REQ-039 Parameter sweep: RD_LAT=1 and WR_LAT=1 -> done at G+1 for both read and write; no overlapping gnt ever observed.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester round-robin memory arbiter: grants one read or write at a time
// and times each access with a 4-bit down-counter. All outputs are registered.
module mem_arbiter #(
  parameter int ADRS_W = 6,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADRS_W-1:0] adrs0,
  input  logic [ADRS_W-1:0] adrs1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADRS_W-1:0] mem_adrs,
  output logic              mem_mode,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_out
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  localparam logic [3:0] RD_CNT = 4'(RD_LAT);
  localparam logic [3:0] WR_CNT = 4'(WR_LAT);

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic              last_gnt, last_gnt_n;
  logic              gnt0_n, gnt1_n, done0_n, done1_n, busy_n, mem_mode_n;
  logic [DATA_W-1:0] rdata_n, mem_data_n;
  logic [ADRS_W-1:0] mem_adrs_n;
  logic              pick, we_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      last_gnt <= 1'b1;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      busy     <= 1'b0;
      rdata    <= '0;
      mem_adrs <= '0;
      mem_mode <= 1'b0;
      mem_data <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      last_gnt <= last_gnt_n;
      gnt0     <= gnt0_n;
      gnt1     <= gnt1_n;
      done0    <= done0_n;
      done1    <= done1_n;
      busy     <= busy_n;
      rdata    <= rdata_n;
      mem_adrs <= mem_adrs_n;
      mem_mode <= mem_mode_n;
      mem_data <= mem_data_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    last_gnt_n = last_gnt;
    gnt0_n     = gnt0;
    gnt1_n     = gnt1;
    done0_n    = 1'b0;
    done1_n    = 1'b0;
    rdata_n    = rdata;
    mem_adrs_n = mem_adrs;
    mem_mode_n = mem_mode;
    mem_data_n = mem_data;
    // On a tie, requester 1 wins only if requester 0 was granted last.
    pick       = req1 && (!req0 || !last_gnt);
    we_sel     = pick ? we1 : we0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          last_gnt_n = pick;
          gnt0_n     = !pick;
          gnt1_n     = pick;
          mem_adrs_n = pick ? adrs1 : adrs0;
          mem_data_n = pick ? wdata1 : wdata0;
          mem_mode_n = we_sel;
          cnt_n      = we_sel ? WR_CNT : RD_CNT;
          state_n    = we_sel ? WRITE : READ;
        end
      end
      READ, WRITE: begin
        // cnt==1 is the last access cycle; cnt==0 is the done cycle.
        if (cnt == 4'd1) begin
          done0_n    = gnt0;
          done1_n    = gnt1;
          mem_mode_n = 1'b0;
          cnt_n      = '0;
          if (state == READ) rdata_n = mem_out;
        end else if (cnt == 4'd0) begin
          state_n = IDLE;
          gnt0_n  = 1'b0;
          gnt1_n  = 1'b0;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = gnt0_n | gnt1_n;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: default-latency instance checked by a
// negedge monitor, plus a RD_LAT=WR_LAT=1 instance checked inline.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [5:0] adrs0 = '0, adrs1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       s_req0 = 0, s_req1 = 0;

  logic       gnt0, gnt1, done0, done1, busy, mem_mode;
  logic [7:0] rdata, mem_data, mem_out;
  logic [5:0] mem_adrs;
  logic       s_gnt0, s_gnt1, s_done0, s_done1, s_busy, s_mem_mode;
  logic [7:0] s_rdata, s_mem_data, s_mem_out;
  logic [5:0] s_mem_adrs;

  logic [7:0] mem  [64];
  logic [7:0] mem1 [64];
  bit         loaded = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct packed {
    logic       who;
    logic       we;
    logic [5:0] adrs;
    logic [7:0] data;
  } exp_t;
  exp_t q[$];

  mem_arbiter #(.ADRS_W(6), .DATA_W(8), .RD_LAT(2), .WR_LAT(3)) u0 (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .adrs0(adrs0), .adrs1(adrs1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .rdata(rdata),
    .busy(busy), .mem_adrs(mem_adrs), .mem_mode(mem_mode), .mem_data(mem_data),
    .mem_out(mem_out));

  mem_arbiter #(.ADRS_W(6), .DATA_W(8), .RD_LAT(1), .WR_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req0(s_req0), .req1(s_req1), .we0(we0), .we1(we1),
    .adrs0(adrs0), .adrs1(adrs1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(s_gnt0), .gnt1(s_gnt1), .done0(s_done0), .done1(s_done1), .rdata(s_rdata),
    .busy(s_busy), .mem_adrs(s_mem_adrs), .mem_mode(s_mem_mode), .mem_data(s_mem_data),
    .mem_out(s_mem_out));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(input int i);
    return (i == 5) ? 8'hA7 : (8'(i) ^ 8'h5A);
  endfunction

  assign mem_out   = mem[mem_adrs];
  assign s_mem_out = mem1[s_mem_adrs];

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 64; i++) begin
        mem[i]  <= init_val(i);
        mem1[i] <= init_val(i);
      end
      loaded <= 1'b1;
    end else begin
      if (mem_mode)   mem[mem_adrs]    <= mem_data;
      if (s_mem_mode) mem1[s_mem_adrs] <= s_mem_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expected entry per done pulse of the main instance.
  bit         in_fl = 0, fall_chk = 0, have_done = 0, chk_gap = 0, g_who = 0;
  int         g_cyc = 0, mode_cnt = 0, last_done = 0;
  logic [7:0] last_rd = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      in_fl = 0; fall_chk = 0; have_done = 0; last_rd = '0;
    end else begin
      check("busy_eq_gnt", 32'(busy), 32'(gnt0 | gnt1));
      check("one_gnt", 32'(gnt0 & gnt1), 0);
      check("one_done", 32'(done0 & done1), 0);
      check("sweep_one_gnt", 32'(s_gnt0 & s_gnt1), 0);
      if (fall_chk) begin
        check("gnt_fall", 32'(g_who ? gnt1 : gnt0), 0);
        fall_chk = 0;
      end
      if (!in_fl && (gnt0 || gnt1)) begin
        in_fl = 1; g_cyc = cyc; g_who = gnt1; mode_cnt = 0;
        if (chk_gap && have_done) check("idle_gap", 32'(cyc - last_done), 2);
      end
      if (in_fl) begin
        if (mem_mode) mode_cnt++;
        if (done0 || done1) begin
          if (q.size() == 0) check("spurious_done", 1, 0);
          else begin
            e = q.pop_front();
            check("done_who", 32'(done1), 32'(e.who));
            check("gnt_who", 32'(g_who), 32'(e.who));
            check("gnt_at_done", 32'(g_who ? gnt1 : gnt0), 1);
            check("latency", 32'(cyc - g_cyc), e.we ? 3 : 2);
            check("mem_adrs", 32'(mem_adrs), 32'(e.adrs));
            if (e.we) begin
              check("mode_cycles", 32'(mode_cnt), 3);
              check("mem_data", 32'(mem_data), 32'(e.data));
              check("rdata_hold", 32'(rdata), 32'(last_rd));
            end else begin
              check("mode_cycles", 32'(mode_cnt), 0);
              check("rdata", 32'(rdata), 32'(e.data));
              last_rd = e.data;
            end
          end
          in_fl = 0; fall_chk = 1; last_done = cyc; have_done = 1;
        end
      end
    end
  end

  task automatic access(input bit who, input bit we, input logic [5:0] a, input logic [7:0] d);
    int n;
    q.push_back({who, we, a, d});
    if (who) begin we1 = we; adrs1 = a; wdata1 = d; req1 = 1; end
    else     begin we0 = we; adrs0 = a; wdata0 = d; req0 = 1; end
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!(who ? gnt1 : gnt0) && n < 30);
    if (n >= 30) begin check("grant_timeout", 0, 1); req0 = 0; req1 = 0; return; end
    @(posedge clk); #1;
    // Scramble the requester's inputs once the access is in flight.
    if (who) begin we1 = ~we; adrs1 = ~a; wdata1 = ~d; req1 = 0; end
    else     begin we0 = ~we; adrs0 = ~a; wdata0 = ~d; req0 = 0; end
    n = 0;
    while (!(done0 || done1) && n < 30) begin @(posedge clk); #1; n++; end
    if (n >= 30) check("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic sweep(input bit who, input bit we, input logic [5:0] a, input logic [7:0] d);
    int n, gc;
    if (who) begin we1 = we; adrs1 = a; wdata1 = d; s_req1 = 1; end
    else     begin we0 = we; adrs0 = a; wdata0 = d; s_req0 = 1; end
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!(who ? s_gnt1 : s_gnt0) && n < 30);
    s_req0 = 0; s_req1 = 0;
    if (n >= 30) begin check("sweep_grant_timeout", 0, 1); return; end
    gc = cyc;
    check("sweep_mode_at_g", 32'(s_mem_mode), 32'(we));
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!(s_done0 || s_done1) && n < 30);
    check("sweep_latency", 32'(cyc - gc), 1);
    check("sweep_done_who", 32'(s_done1), 32'(who));
    if (we) begin
      check("sweep_mode_off", 32'(s_mem_mode), 0);
      check("sweep_mem_data", 32'(s_mem_data), 32'(d));
    end else check("sweep_rdata", 32'(s_rdata), 32'(d));
    @(posedge clk); #1;
    check("sweep_gnt_fall", 32'(s_gnt0 | s_gnt1), 0);
  endtask

  initial begin
    int n, dn;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", 32'({gnt0, gnt1, s_gnt0, s_gnt1}), 0);
    check("rst_done_busy", 32'({done0, done1, busy, s_busy}), 0);
    check("rst_mem_mode", 32'(mem_mode), 0);
    check("rst_mem_adrs", 32'(mem_adrs), 0);
    check("rst_mem_data", 32'(mem_data), 0);
    check("rst_rdata", 32'(rdata), 0);
    rst_n = 1;
    @(posedge clk); #1;

    access(0, 0, 6'd5,  8'hA7);
    access(1, 1, 6'd9,  8'h3C);
    access(0, 0, 6'd9,  8'h3C);
    access(1, 0, 6'd7,  8'h5D);
    access(0, 1, 6'd20, 8'h81);
    access(1, 0, 6'd20, 8'h81);

    // Reset one cycle into a write.
    we1 = 1; adrs1 = 6'd12; wdata1 = 8'h55; req1 = 1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!gnt1 && n < 30);
    if (n >= 30) check("rst_grant_timeout", 0, 1);
    @(posedge clk); #1;
    check("mode_before_rst", 32'(mem_mode), 1);
    rst_n = 0; req1 = 0;
    #1;
    check("rst_mid_mode", 32'(mem_mode), 0);
    check("rst_mid_gnt", 32'(gnt0 | gnt1), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_adrs", 32'(mem_adrs), 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    // Both requesters held high: 0,1,0,1 with one IDLE cycle between.
    chk_gap = 1;
    we0 = 0; adrs0 = 6'd5; we1 = 0; adrs1 = 6'd9;
    q.push_back({1'b0, 1'b0, 6'd5, 8'hA7});
    q.push_back({1'b1, 1'b0, 6'd9, 8'h3C});
    q.push_back({1'b0, 1'b0, 6'd5, 8'hA7});
    q.push_back({1'b1, 1'b0, 6'd9, 8'h3C});
    req0 = 1; req1 = 1;
    dn = 0; n = 0;
    while (dn < 4 && n < 80) begin
      @(posedge clk); #1; n++;
      if (done0 || done1) dn++;
    end
    req0 = 0; req1 = 0;
    if (dn < 4) check("tie_timeout", 32'(dn), 4);
    repeat (3) @(posedge clk);
    #1;
    chk_gap = 0;

    sweep(0, 0, 6'd5,  8'hA7);
    sweep(1, 1, 6'd33, 8'h99);
    sweep(0, 0, 6'd33, 8'h99);
    sweep(1, 0, 6'd7,  8'h5D);

    n = 0;
    while (q.size() != 0 && n < 50) begin @(posedge clk); n++; end
    check("queue_empty", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
